// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM encoding and
// the iteration-counter width helper.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must hold WIDTH+1 (the load value), so size it for WIDTH+2 states.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_shift_reg.sv
// Booth accumulator {A,Qr,q_m1}: parallel load, or add/sub of m_ext followed
// by a one-bit arithmetic right shift of the whole register.
module booth_shift_reg
    import booth_pkg::*;
#(
    parameter int N = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [1:0]       op,
    input  logic [N-1:0]     m_ext,
    input  logic [N-1:0]     q_ext,
    output logic [1:0]       lsb_pair,
    output logic [2*N-3:0]   prod_nxt
);

    logic [N:0]          a;
    logic [N-1:0]        qr;
    logic                q_m1;
    logic signed [N:0]   a_s;
    logic signed [N:0]   m_s;
    logic signed [N:0]   sum;
    logic [N:0]          a_nxt;
    logic [N-1:0]        qr_nxt;

    // A carries one guard bit beyond the extended operand, so the add/sub cannot overflow.
    always_comb begin
        a_s = a;
        m_s = {m_ext[N-1], m_ext};
        unique case (op)
            2'b01:   sum = a_s + m_s;
            2'b10:   sum = a_s - m_s;
            default: sum = a_s;
        endcase
        a_nxt  = {sum[N], sum[N:1]};
        qr_nxt = {sum[0], qr[N-1:1]};
    end

    assign lsb_pair = {qr[0], q_m1};
    assign prod_nxt = {a_nxt[N-3:0], qr_nxt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a    <= '0;
            qr   <= '0;
            q_m1 <= 1'b0;
        end else if (load) begin
            a    <= '0;
            qr   <= q_ext;
            q_m1 <= 1'b0;
        end else if (shift) begin
            a    <= a_nxt;
            qr   <= qr_nxt;
            q_m1 <= qr[0];
        end
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake and a
// per-operation signed/unsigned mode. One iteration per cycle, WIDTH+1 iterations.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int N  = WIDTH + 1;
    localparam int CW = cnt_width(WIDTH);

    state_t               state;
    state_t               state_nx;
    logic [CW-1:0]        cnt;
    logic [N-1:0]         m_ext;
    logic [N-1:0]         q_ext;
    logic [N-1:0]         m_reg;
    logic [1:0]           op;
    logic                 load;
    logic                 shift;
    logic                 last;
    logic [2*WIDTH-1:0]   prod_nxt;

    // One extra bit lets unsigned operands with the MSB set go through the signed Booth recoding.
    assign m_ext = {is_signed & multiplicand[WIDTH-1], multiplicand};
    assign q_ext = {is_signed & multiplier[WIDTH-1], multiplier};

    assign busy = (state == RUN);
    assign last = (state == RUN) && (cnt == CW'(1));

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (cnt == CW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            m_reg <= '0;
        end else if (load) begin
            cnt   <= CW'(N);
            m_reg <= m_ext;
        end else if (shift) begin
            cnt   <= cnt - CW'(1);
        end
    end

    booth_shift_reg #(
        .N (N)
    ) u_shift_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .op       (op),
        .m_ext    (m_reg),
        .q_ext    (q_ext),
        .lsb_pair (op),
        .prod_nxt (prod_nxt)
    );

    // Product is captured from the final iteration's result so it is valid alongside done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= last;
            if (last) begin
                product <= prod_nxt;
            end
        end
    end

endmodule
